alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational ALU (alu_if slave) between two requesters, e.g. two cores' execute stages in the multicore build.
- Latches the granted requester's opcode and operands, drives the shared ALU for one cycle, registers result and flags, and returns a one-cycle ack to that requester.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
- DW, 32, operand/result width.
- OPW, 4, ALU opcode width (aluop_t from cpu_types_pkg).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- req  in  2  per-requester request; held high with operands stable until ack.
- opcode0, opcode1  in  OPW  requester ALU opcode.
- op1_0, op2_0, op1_1, op2_1  in  DW  requester operands.
- ack  out  2  one-hot, one-cycle pulse; result valid in that cycle.
- res  out  DW  registered ALU result.
- flag_v, flag_n, flag_z  out  1  registered ALU flags.
- alu_opcode  out  OPW  to shared ALU.
- alu_op1, alu_op2  out  DW  to shared ALU.
- alu_res  in  DW  from shared ALU.
- alu_v, alu_n, alu_z  in  1  from shared ALU.

Behaviour:
- Reset: nRST sampled low at a rising edge sets state IDLE, ack=0, res=0, all flags=0, latched opcode/operands=0 (so alu_* outputs=0), and last-grant pointer=1 (requester 0 wins first contention).
- States: IDLE, EXEC, DONE.
- IDLE, no req: stay.
- IDLE, exactly one req bit set: grant that requester, latch its opcode/op1/op2, go to EXEC.
- IDLE, both req set: grant the requester not equal to the last-grant pointer, latch its operands, go to EXEC.
- EXEC: alu_* outputs are driven from the latch only, never combinationally from requester ports. At the edge, capture alu_res/alu_v/alu_n/alu_z into res/flags and go to DONE.
- DONE: ack[granted]=1 for exactly this cycle. At the edge, update the last-grant pointer to the granted requester and go to IDLE.
- Latency: req sampled at edge k; ack and result visible in cycle k+2. Throughput is one operation per 3 cycles.
- Requester rule: in the cycle after its ack, the requester either drops req or presents a new operation. Because the pointer has just been updated, an immediate re-request loses to a pending request from the other requester.
- res/flags hold their last captured value outside DONE. Outputs are only qualified by ack.
- Changes on req or operands outside IDLE are ignored. Operands are sampled only at the grant edge.
- Dropping req while in EXEC or DONE does not cancel: the operation completes and ack still pulses.
- Reset mid-operation: the in-flight operation is discarded with no ack, and all reset values apply at the next cycle.
- X on alu_v/alu_n/alu_z is captured as-is. The bench checks flags only for opcodes that define them.

Optional Feature:
- Macro ALU_ARB_PERF_EN.
- Defined: adds output ports grant_cnt0 and grant_cnt1 (16 bits each), plus conflict_cnt (16 bits) counting IDLE cycles with req==2'b11.
  - grant_cnt0/grant_cnt1 increment on each DONE cycle for their requester.
  - All counters saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset, then req=2'b01, opcode0=ALU_ADD, op1_0=5, op2_0=7 -> ack=2'b01 exactly 2 cycles after the req edge; res=12, flag_z=0, flag_n=0.
- Reset, then req=2'b11 held: req0 ALU_SUB 3-3, req1 ALU_OR 0xF0|0x0F -> first ack=2'b01 with res=0, flag_z=1. Next ack=2'b10 three cycles later with res=0x000000FF. Grants then continue alternating.
- req1 only, ALU_ADD 0x7FFFFFFF+1 -> ack=2'b10, res=0x80000000, flag_n=1. res stays 0x80000000 in following idle cycles.
- nRST low during EXEC of a req0 ALU_AND -> no ack pulse; res=0, ack=0; next req1 request wins and completes normally.
- Operands changed in EXEC (op1_0 5->9) -> result uses the latched 5; alu_op1 stays 5 until DONE.
- With ALU_ARB_PERF_EN, 4 contended operations -> grant_cnt0=2, grant_cnt1=2, conflict_cnt>=1. Preload 0xFFFF -> counter holds at 0xFFFF.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Round-robin arbiter/sequencer that shares one combinational ALU between
// two requesters. The granted requester's opcode and operands are latched,
// driven to the shared ALU for one cycle, and the result and flags are then
// registered. A one-cycle one-hot ack is returned in the DONE cycle.
//
// Ports:
//   CLK                 rising-edge clock
//   nRST                synchronous active-low reset
//   req[1:0]            per-requester request (held until ack)
//   opcode0/1, op1_x/op2_x  requester opcode and operands
//   ack[1:0]            one-hot, one-cycle completion pulse
//   res, flag_v/n/z     registered ALU result and flags
//   alu_opcode/op1/op2  latched operation driven to the shared ALU
//   alu_res, alu_v/n/z  shared ALU result and flags
//
// Optional build macro ALU_ARB_PERF_EN adds grant_cnt0, grant_cnt1 and
// conflict_cnt (16-bit saturating performance counters).
module alu_arbiter #(
  parameter int DW  = 32,
  parameter int OPW = 4
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic [1:0]     req,
  input  logic [OPW-1:0] opcode0,
  input  logic [OPW-1:0] opcode1,
  input  logic [DW-1:0]  op1_0,
  input  logic [DW-1:0]  op2_0,
  input  logic [DW-1:0]  op1_1,
  input  logic [DW-1:0]  op2_1,
  output logic [1:0]     ack,
  output logic [DW-1:0]  res,
  output logic           flag_v,
  output logic           flag_n,
  output logic           flag_z,
  output logic [OPW-1:0] alu_opcode,
  output logic [DW-1:0]  alu_op1,
  output logic [DW-1:0]  alu_op2,
  input  logic [DW-1:0]  alu_res,
  input  logic           alu_v,
  input  logic           alu_n,
  input  logic           alu_z
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]    grant_cnt0,
  output logic [15:0]    grant_cnt1,
  output logic [15:0]    conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   sel_s;    // requester chosen in IDLE
  logic   gnt_r;    // requester currently being served
  logic   last_r;   // last-grant pointer; contention goes to the other one

  // Requester selection and next-state decode
  always_comb begin
    sel_s       = 1'b0;
    state_nxt_s = state_r;
    case (req)
      2'b01:   sel_s = 1'b0;
      2'b10:   sel_s = 1'b1;
      2'b11:   sel_s = ~last_r;
      default: sel_s = 1'b0;
    endcase
    case (state_r)
      IDLE: begin
        if (req != 2'b00) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC:    state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register, operand latch, result capture and ack generation
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r    <= IDLE;
      gnt_r      <= 1'b0;
      last_r     <= 1'b1;
      ack        <= 2'b00;
      res        <= {DW{1'b0}};
      flag_v     <= 1'b0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b0;
      alu_opcode <= {OPW{1'b0}};
      alu_op1    <= {DW{1'b0}};
      alu_op2    <= {DW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ack     <= 2'b00;
      case (state_r)
        IDLE: begin
          if (req != 2'b00) begin
            gnt_r <= sel_s;
            // Operands are sampled only here; later changes are ignored.
            if (sel_s) begin
              alu_opcode <= opcode1;
              alu_op1    <= op1_1;
              alu_op2    <= op2_1;
            end else begin
              alu_opcode <= opcode0;
              alu_op1    <= op1_0;
              alu_op2    <= op2_0;
            end
          end else begin
            gnt_r <= gnt_r;
          end
        end
        EXEC: begin
          res    <= alu_res;
          flag_v <= alu_v;
          flag_n <= alu_n;
          flag_z <= alu_z;
          // ack is registered so it coincides with the DONE cycle.
          ack    <= gnt_r ? 2'b10 : 2'b01;
        end
        DONE: begin
          last_r <= gnt_r;
        end
        default: begin
          last_r <= last_r;
        end
      endcase
    end
  end

`ifdef ALU_ARB_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 16'd1;
    end
  endfunction

  // Saturating grant and contention counters
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      grant_cnt0   <= 16'd0;
      grant_cnt1   <= 16'd0;
      conflict_cnt <= 16'd0;
    end else begin
      if ((state_r == DONE) && !gnt_r) begin
        grant_cnt0 <= sat_inc(grant_cnt0);
      end
      if ((state_r == DONE) && gnt_r) begin
        grant_cnt1 <= sat_inc(grant_cnt1);
      end
      if ((state_r == IDLE) && (req == 2'b11)) begin
        conflict_cnt <= sat_inc(conflict_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Directed bench for alu_arbiter in its default build. A small behavioural
// ALU drives alu_res/alu_v/alu_n/alu_z from the arbiter's alu_* outputs.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_alu_arbiter;

  localparam int DW  = 32;
  localparam int OPW = 4;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  logic           CLK;
  logic           nRST;
  logic [1:0]     req;
  logic [OPW-1:0] opcode0, opcode1;
  logic [DW-1:0]  op1_0, op2_0, op1_1, op2_1;
  logic [1:0]     ack;
  logic [DW-1:0]  res;
  logic           flag_v, flag_n, flag_z;
  logic [OPW-1:0] alu_opcode;
  logic [DW-1:0]  alu_op1, alu_op2;
  logic [DW-1:0]  alu_res;
  logic           alu_v, alu_n, alu_z;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
    .CLK(CLK), .nRST(nRST), .req(req),
    .opcode0(opcode0), .opcode1(opcode1),
    .op1_0(op1_0), .op2_0(op2_0), .op1_1(op1_1), .op2_1(op2_1),
    .ack(ack), .res(res), .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_res(alu_res), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural shared ALU
  always_comb begin
    alu_res = 32'd0;
    alu_v   = 1'b0;
    case (alu_opcode)
      ALU_ADD: begin
        alu_res = alu_op1 + alu_op2;
        alu_v   = (alu_op1[31] == alu_op2[31]) && (alu_res[31] != alu_op1[31]);
      end
      ALU_SUB: begin
        alu_res = alu_op1 - alu_op2;
        alu_v   = (alu_op1[31] != alu_op2[31]) && (alu_res[31] != alu_op1[31]);
      end
      ALU_AND: alu_res = alu_op1 & alu_op2;
      ALU_OR:  alu_res = alu_op1 | alu_op2;
      default: alu_res = 32'd0;
    endcase
    alu_n = alu_res[31];
    alu_z = (alu_res == 32'd0);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; req = 2'b00;
    opcode0 = 4'd0; opcode1 = 4'd0;
    op1_0 = 32'd0; op2_0 = 32'd0; op1_1 = 32'd0; op2_1 = 32'd0;
    tick(); tick();

    // Reset state
    check("rst_ack", {30'd0, ack}, 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_flags", {29'd0, flag_v, flag_n, flag_z}, 32'd0);
    check("rst_alu_op1", alu_op1, 32'd0);
    check("rst_alu_op2", alu_op2, 32'd0);
    check("rst_alu_opc", {28'd0, alu_opcode}, 32'd0);

    // Single request from 0: ADD 5+7, operand changed during EXEC
    nRST = 1'b1; req = 2'b01; opcode0 = ALU_ADD; op1_0 = 32'd5; op2_0 = 32'd7;
    tick();                                   // grant edge -> EXEC
    check("t1_exec_ack", {30'd0, ack}, 32'd0);
    check("t1_exec_alu_op1", alu_op1, 32'd5);
    op1_0 = 32'd9;
    tick();                                   // -> DONE
    check("t1_ack", {30'd0, ack}, 32'd1);
    check("t1_res", res, 32'd12);
    check("t1_nz", {30'd0, flag_n, flag_z}, 32'd0);
    check("t1_done_alu_op1", alu_op1, 32'd5);
    req = 2'b00;
    tick();
    check("t1_ack_clear", {30'd0, ack}, 32'd0);
    check("t1_res_hold", res, 32'd12);

    // Contention: pointer after reset favours requester 0
    nRST = 1'b0; tick();
    nRST = 1'b1; req = 2'b11;
    opcode0 = ALU_SUB; op1_0 = 32'd3;    op2_0 = 32'd3;
    opcode1 = ALU_OR;  op1_1 = 32'hF0;   op2_1 = 32'h0F;
    tick(); tick();
    check("t2_ack0", {30'd0, ack}, 32'd1);
    check("t2_res0", res, 32'd0);
    check("t2_z0", {31'd0, flag_z}, 32'd1);
    tick();                                   // IDLE, both requesting
    check("t2_idle_ack", {30'd0, ack}, 32'd0);
    tick(); tick();
    check("t2_ack1", {30'd0, ack}, 32'd2);
    check("t2_res1", res, 32'h000000FF);
    check("t2_z1", {31'd0, flag_z}, 32'd0);
    tick(); tick(); tick();
    check("t2_ack_alt", {30'd0, ack}, 32'd1);
    check("t2_res_alt", res, 32'd0);

    // Requester 1 only: signed overflow into bit 31
    req = 2'b10; opcode1 = ALU_ADD; op1_1 = 32'h7FFFFFFF; op2_1 = 32'd1;
    tick();                                   // leaves DONE
    tick(); tick();
    check("t3_ack", {30'd0, ack}, 32'd2);
    check("t3_res", res, 32'h80000000);
    check("t3_n", {31'd0, flag_n}, 32'd1);
    check("t3_v", {31'd0, flag_v}, 32'd1);
    req = 2'b00;
    tick(); tick();
    check("t3_res_hold", res, 32'h80000000);
    check("t3_idle_ack", {30'd0, ack}, 32'd0);

    // Reset during EXEC discards the operation
    req = 2'b01; opcode0 = ALU_AND; op1_0 = 32'hF0; op2_0 = 32'h3C;
    tick();                                   // EXEC
    nRST = 1'b0; req = 2'b00;
    tick();
    check("t4_rst_ack", {30'd0, ack}, 32'd0);
    check("t4_rst_res", res, 32'd0);
    check("t4_rst_alu_op1", alu_op1, 32'd0);
    nRST = 1'b1; req = 2'b10; opcode1 = ALU_ADD; op1_1 = 32'd1; op2_1 = 32'd2;
    tick();
    check("t4_no_ack", {30'd0, ack}, 32'd0);
    tick();
    check("t4_ack1", {30'd0, ack}, 32'd2);
    check("t4_res1", res, 32'd3);
    req = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
